// File: rtl/display_scan_controller_if.sv
// Bundle between the watch datapath and the scan controller: eight digit words in,
// multiplexed anode/segment drive and frame marker out.
interface display_scan_controller_if;
    logic [5:0] d1;
    logic [5:0] d2;
    logic [5:0] d3;
    logic [5:0] d4;
    logic [5:0] d5;
    logic [5:0] d6;
    logic [5:0] d7;
    logic [5:0] d8;
    logic [7:0] an;
    logic [7:0] dec_ddp;
    logic       frame_start;

    modport master (
        output d1, d2, d3, d4, d5, d6, d7, d8,
        input  an, dec_ddp, frame_start
    );

    modport slave (
        input  d1, d2, d3, d4, d5, d6, d7, d8,
        output an, dec_ddp, frame_start
    );
endinterface

// File: rtl/display_scan_controller.sv
// Round-robin scan of eight digit words onto a common-anode 7-segment display,
// with a blanking interval ahead of every slot to suppress ghosting.
//
// state | meaning
// BLANK | all anodes and segments off; counting BLANK_CYCLES clocks
// SHOW  | one anode on, driving the word captured at the end of BLANK
module display_scan_controller #(
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic                      clock,
    input  logic                      reset,
    display_scan_controller_if.slave  bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);

    localparam logic [0:0] BLANK = 1'b0;
    localparam logic [0:0] SHOW  = 1'b1;

    generate
        if (BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_param_check
            $error("display_scan_controller: need 1 <= BLANK_CYCLES < REFRESH_DIV");
        end
    endgenerate

    logic [0:0]       state;
    logic [2:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       word;

    always_comb begin
        word = bus.d1;
        case (idx)
            3'd0: word = bus.d1;
            3'd1: word = bus.d2;
            3'd2: word = bus.d3;
            3'd3: word = bus.d4;
            3'd4: word = bus.d5;
            3'd5: word = bus.d6;
            3'd6: word = bus.d7;
            3'd7: word = bus.d8;
            default: word = bus.d1;
        endcase
    end

    // abcdefg, active-low
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    // The output registers double as the slot's shadow copy: they are loaded only
    // on the BLANK->SHOW edge, so input changes during SHOW never reach the pins.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= BLANK;
            idx             <= 3'd0;
            cnt             <= '0;
            bus.an          <= 8'hFF;
            bus.dec_ddp     <= 8'hFF;
            bus.frame_start <= 1'b0;
        end else begin
            bus.frame_start <= 1'b0;
            case (state)
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= SHOW;
                        cnt   <= '0;
                        if (word[5]) begin
                            bus.an      <= ~(8'b1 << idx);
                            bus.dec_ddp <= {hex7(word[4:1]), word[0]};
                        end else begin
                            bus.an      <= 8'hFF;
                            bus.dec_ddp <= 8'hFF;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state           <= BLANK;
                        cnt             <= '0;
                        idx             <= idx + 3'd1;
                        bus.an          <= 8'hFF;
                        bus.dec_ddp     <= 8'hFF;
                        bus.frame_start <= (idx == 3'd7);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= BLANK;
            endcase
        end
    end
endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller: a slot-timeline model predicts each cycle's
// outputs into a queue, which is popped and compared after every clock edge.
module tb_display_scan_controller;
    localparam int RD = 10;
    localparam int BC = 2;
    localparam int FRAME = 8 * RD;

    logic clock = 1'b0;
    logic reset = 1'b1;

    display_scan_controller_if bus();

    display_scan_controller #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    logic [5:0] d [8];
    assign bus.d1 = d[0];
    assign bus.d2 = d[1];
    assign bus.d3 = d[2];
    assign bus.d4 = d[3];
    assign bus.d5 = d[4];
    assign bus.d6 = d[5];
    assign bus.d7 = d[6];
    assign bus.d8 = d[7];

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
        logic       fs;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   t = 0;
    logic [5:0] lat = 6'd0;

    logic [6:0] hex_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Predict the outputs that follow the coming edge, given the inputs driven now.
    task automatic predict();
        exp_t e;
        int ph;
        int slot;
        logic [7:0] one;
        e.an  = 8'hFF;
        e.seg = 8'hFF;
        e.fs  = 1'b0;
        if (reset) begin
            t = 0;
        end else begin
            t++;
            ph   = t % RD;
            slot = (t / RD) % 8;
            if (ph < BC) begin
                e.fs = (ph == 0) && (slot == 0);
            end else begin
                if (ph == BC) lat = d[slot];
                if (lat[5]) begin
                    one   = 8'b1 << slot;
                    e.an  = ~one;
                    e.seg = {hex_tab[lat[4:1]], lat[0]};
                end
            end
        end
        sbq.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        predict();
        @(posedge clock);
        #1;
        e = sbq.pop_front();
        checks++;
        assert (bus.an === e.an) else begin
            failures++;
            $error("FAIL an t=%0d got=%h exp=%h", t, bus.an, e.an);
        end
        checks++;
        assert (bus.dec_ddp === e.seg) else begin
            failures++;
            $error("FAIL dec_ddp t=%0d got=%b exp=%b", t, bus.dec_ddp, e.seg);
        end
        checks++;
        assert (bus.frame_start === e.fs) else begin
            failures++;
            $error("FAIL frame_start t=%0d got=%b exp=%b", t, bus.frame_start, e.fs);
        end
        checks++;
        assert ($countones(~bus.an) <= 1) else begin
            failures++;
            $error("FAIL an_onehot t=%0d got=%h exp=at_most_one_low", t, bus.an);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until(input int pos);
        for (int i = 0; i < FRAME; i++) begin
            if (t % FRAME == pos) break;
            cycle();
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) d[k] = 6'd0;
        d[0] = 6'b1_0011_1;

        // reset state, then first slot: 2 blank clocks, then '3' on digit 0
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(RD);

        // all digits enabled with distinct values, two frames, both dp states
        for (int k = 0; k < 8; k++) d[k] = {1'b1, 4'(k), 1'(k)};
        run_until(0);
        run(FRAME);
        for (int k = 0; k < 8; k++) d[k] = {1'b1, 4'(k + 8), 1'(k + 1)};
        run(FRAME);

        // disabled digit 3 still consumes its slot
        d[2][5] = 1'b0;
        run(FRAME);
        d[2][5] = 1'b1;

        // mid-slot change of d1 is ignored until next frame
        d[0] = 6'b1_0001_1;
        run_until(FRAME - 1);
        run_until(BC + 3);
        d[0] = 6'b1_1000_0;
        run(FRAME + RD);

        // random words over a frame
        for (int k = 0; k < 8; k++) d[k] = 6'($urandom);
        run(FRAME);

        // reset during slot 5 SHOW, scan restarts at slot 0
        run_until(5 * RD + BC + 2);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(FRAME + 2 * RD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
